mul_hilo_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mul.sv | 16 +
 rtl/mul_hilo_unit.sv | 133 +++++++++++++
 tb/tb_mul_hilo_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/HI-LO sequencer.
//   DATA_W        : datapath width of HI, LO and each multiply operand
//   OP_*          : 2-bit multiply-unit operation codes from the execute stage
//   ST_*          : multiply sequencer state encodings
package cpu_pkg;

   localparam int unsigned DATA_W = 24;

   localparam logic [1:0] OP_MULU = 2'b00;  // unsigned multiply
   localparam logic [1:0] OP_MUL  = 2'b01;  // signed two's complement multiply
   localparam logic [1:0] OP_MTHI = 2'b10;  // direct write of HI
   localparam logic [1:0] OP_MTLO = 2'b11;  // direct write of LO

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_RUN     = 2'b01;
   // The capture step is the single RUN edge where the counter reaches 0.
   // The state register passes straight through it back to IDLE.
   localparam logic [1:0] ST_CAPTURE = 2'b10;

endpackage

// File: rtl/mul.sv
// Combinational unsigned multiplier array. It is a multicycle path, so the
// sequencer holds its inputs stable for several cycles before sampling prod.
//   a    : operand A (unsigned)
//   b    : operand B (unsigned)
//   prod : full-width unsigned product a*b
module mul #(
   parameter int unsigned W = 24
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] prod
);

   assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/mul_hilo_unit.sv
// Multi-cycle multiply sequencer with HI/LO result registers.
// Latches operand magnitudes on a start request, holds them stable for
// MUL_CYCLES cycles while the combinational array settles, then writes the
// sign-corrected product into HI (upper half) and LO (lower half).
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   start : request strobe, honoured only when not busy
//   op    : MULU / MUL / MTHI / MTLO
//   a, b  : operands; a is also the MTHI/MTLO write data
//   busy  : multiply in flight, stalls the core
//   done  : one-cycle pulse when HI/LO hold a new product
//   hi,lo : HI/LO registers
module mul_hilo_unit #(
   parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   import cpu_pkg::*;

   localparam int unsigned CNT_W = 4;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic                neg_q, neg_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                done_q, done_d;

   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] result;
   logic                is_signed;
   logic                a_neg;
   logic                b_neg;

   mul #(
      .W (DATA_W)
   ) u_mul (
      .a    (opa_q),
      .b    (opb_q),
      .prod (prod)
   );

   // Sign magnitudes are only taken for MUL; MULU latches the raw bits.
   assign is_signed = (op == OP_MUL);
   assign a_neg     = is_signed & a[DATA_W-1];
   assign b_neg     = is_signed & b[DATA_W-1];

   // 0x800000 negates to itself, which read as unsigned is the right magnitude.
   assign result = neg_q ? (~prod + 1'b1) : prod;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULU, OP_MUL: begin
                     opa_d   = a_neg ? (~a + 1'b1) : a;
                     opb_d   = b_neg ? (~b + 1'b1) : b;
                     neg_d   = a_neg ^ b_neg;
                     cnt_d   = CNT_W'(MUL_CYCLES - 1);
                     state_d = ST_RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Requests arriving here are dropped: the core is stalled on busy.
            if (cnt_q == '0) begin
               hi_d    = result[2*DATA_W-1:DATA_W];
               lo_d    = result[DATA_W-1:0];
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Scoreboard bench for mul_hilo_unit: expected {hi,lo} pushed at request
// time, popped and compared whenever done pulses.
module tb_mul_hilo_unit;

   localparam int unsigned W  = 24;
   localparam int unsigned MC = 4;

   logic          clk;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   logic [2*W-1:0] sb_q[$];
   int n_cmp;
   int n_err;
   int n_done;

   mul_hilo_unit #(
      .DATA_W     (W),
      .MUL_CYCLES (MC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer.
   always @(negedge clk) begin
      logic [2*W-1:0] exp_v;
      if (!reset && done === 1'b1) begin
         n_done++;
         if (sb_q.size() == 0) begin
            check_val("spurious_done", {63'd0, done}, 64'd0);
         end else begin
            exp_v = sb_q.pop_front();
            check_val("sb_hi", {40'd0, hi}, {40'd0, exp_v[2*W-1:W]});
            check_val("sb_lo", {40'd0, lo}, {40'd0, exp_v[W-1:0]});
         end
      end
   end

   // Drive one request for a single cycle; returns at the first busy sample.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = va;
      b     = vb;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy cycles (bounded) and then expects the done pulse.
   task automatic wait_done(input string tag);
      int cnt;
      cnt = 0;
      while (busy && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      check_val({tag, "_busy_cycles"}, 64'(cnt), 64'(MC));
      check_val({tag, "_done"}, {63'd0, done}, 64'd1);
   endtask

   initial begin
      int saved;
      int gap;
      n_cmp  = 0;
      n_err  = 0;
      n_done = 0;
      reset  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;

      repeat (2) @(negedge clk);
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_done", {63'd0, done}, 64'd0);
      check_val("rst_hi", {40'd0, hi}, 64'd0);
      check_val("rst_lo", {40'd0, lo}, 64'd0);
      reset = 1'b0;

      // Unsigned max * max.
      sb_q.push_back({24'hFFFFFE, 24'h000001});
      issue(2'b00, 24'hFFFFFF, 24'hFFFFFF);
      wait_done("mulu_max");

      // Signed -2 * 3.
      sb_q.push_back({24'hFFFFFF, 24'hFFFFFA});
      issue(2'b01, 24'hFFFFFE, 24'h000003);
      wait_done("mul_neg");

      // Most-negative squared.
      sb_q.push_back({24'h400000, 24'h000000});
      issue(2'b01, 24'h800000, 24'h800000);
      wait_done("mul_minsq");

      // MTHI then MTLO on consecutive cycles.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      a     = 24'h123456;
      @(negedge clk);
      check_val("mthi_hi", {40'd0, hi}, 64'h123456);
      check_val("mthi_busy", {63'd0, busy}, 64'd0);
      check_val("mthi_done", {63'd0, done}, 64'd0);
      op = 2'b11;
      a  = 24'hABCDEF;
      @(negedge clk);
      start = 1'b0;
      check_val("mtlo_lo", {40'd0, lo}, 64'hABCDEF);
      check_val("mtlo_hi", {40'd0, hi}, 64'h123456);
      check_val("mtlo_busy", {63'd0, busy}, 64'd0);
      check_val("mtlo_done", {63'd0, done}, 64'd0);

      // Requests during busy are ignored.
      saved = n_done;
      sb_q.push_back({24'h000000, 24'h000100});
      issue(2'b00, 24'h000010, 24'h000010);
      start = 1'b1;
      op    = 2'b00;
      a     = 24'h000002;
      b     = 24'h000002;
      @(negedge clk);
      op = 2'b10;
      a  = 24'h777777;
      @(negedge clk);
      start = 1'b0;
      check_val("ign_hi_during", {40'd0, hi}, 64'h123456);
      check_val("ign_busy", {63'd0, busy}, 64'd1);
      begin
         int k;
         k = 0;
         while (!done && k < 20) begin
            k++;
            @(negedge clk);
         end
         check_val("ign_done", {63'd0, done}, 64'd1);
      end
      repeat (10) @(negedge clk);
      check_val("ign_hi", {40'd0, hi}, 64'h000000);
      check_val("ign_lo", {40'd0, lo}, 64'h000100);
      check_val("ign_done_count", 64'(n_done - saved), 64'd1);

      // Asynchronous reset in the second RUN cycle.
      saved = n_done;
      issue(2'b00, 24'h000005, 24'h000007);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("arst_busy", {63'd0, busy}, 64'd0);
      check_val("arst_done", {63'd0, done}, 64'd0);
      check_val("arst_hi", {40'd0, hi}, 64'd0);
      check_val("arst_lo", {40'd0, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check_val("arst_no_done", 64'(n_done - saved), 64'd0);
      check_val("arst_hi_after", {40'd0, hi}, 64'd0);

      // Back-to-back: new MUL issued in the done cycle of a MULU.
      sb_q.push_back({24'h000000, 24'h00000F});
      issue(2'b00, 24'h000003, 24'h000005);
      wait_done("b2b_first");
      sb_q.push_back({24'h000000, 24'h000001});
      start = 1'b1;
      op    = 2'b01;
      a     = 24'hFFFFFF;
      b     = 24'hFFFFFF;
      @(negedge clk);
      start = 1'b0;
      check_val("b2b_busy", {63'd0, busy}, 64'd1);
      gap = 0;
      while (!done && gap < 20) begin
         gap++;
         @(negedge clk);
      end
      // Cycles strictly between the two done pulses are the busy window.
      check_val("b2b_gap", 64'(gap), 64'(MC));
      check_val("b2b_done", {63'd0, done}, 64'd1);

      repeat (3) @(negedge clk);
      check_val("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
